// File: rtl/serdesphy_reset_sequencer_if.sv
// ---------------------------------------------------------------------------
// serdesphy_reset_sequencer_if
//
// Bundles the control inputs and the reset/status outputs of the SerDes PHY
// power-up and reset sequencer. The sequencer connects through the slave
// modport. Whatever drives supply flags, enable, isolation force and soft-reset
// requests connects through the master modport.
//
// Signals:
//   supply_ok       [NUM_SUPPLY]  per-supply good flags (already synchronous)
//   phy_en                        PHY enable
//   iso_en                        force analog isolation
//   domain_rst_req  [NUM_DOMAINS] per-domain soft-reset request (level)
//   analog_iso_n                  analog isolation release (low = isolate)
//   analog_reset_n                analog reset release
//   digital_reset_n               digital core reset release
//   domain_rst_n    [NUM_DOMAINS] per-domain reset releases
//   power_good                    supplies qualified
//   por_active                    power-up sequence in progress
//   por_complete                  sequence finished, in RUN
//   fault                         sticky supply-loss flag
//   state           [3]           current state encoding
// ---------------------------------------------------------------------------
interface serdesphy_reset_sequencer_if #(
    parameter int NUM_SUPPLY  = 2,
    parameter int NUM_DOMAINS = 3
);
    logic [NUM_SUPPLY-1:0]  supply_ok;
    logic                   phy_en;
    logic                   iso_en;
    logic [NUM_DOMAINS-1:0] domain_rst_req;
    logic                   analog_iso_n;
    logic                   analog_reset_n;
    logic                   digital_reset_n;
    logic [NUM_DOMAINS-1:0] domain_rst_n;
    logic                   power_good;
    logic                   por_active;
    logic                   por_complete;
    logic                   fault;
    logic [2:0]             state;

    modport master (
        output supply_ok, phy_en, iso_en, domain_rst_req,
        input  analog_iso_n, analog_reset_n, digital_reset_n, domain_rst_n,
        input  power_good, por_active, por_complete, fault, state
    );

    modport slave (
        input  supply_ok, phy_en, iso_en, domain_rst_req,
        output analog_iso_n, analog_reset_n, digital_reset_n, domain_rst_n,
        output power_good, por_active, por_complete, fault, state
    );
endinterface

// File: rtl/serdesphy_reset_sequencer.sv
// ---------------------------------------------------------------------------
// serdesphy_reset_sequencer
//
// Power-up and reset sequencer for the SerDes PHY, clocked from the 24 MHz
// reference. It qualifies NUM_SUPPLY supply-good flags for STABLE_CYCLES
// consecutive cycles, then releases analog isolation, analog reset, digital
// reset and NUM_DOMAINS domain resets in order, dwelling STEP_CYCLES per step.
// In RUN each domain can be soft-reset for STEP_CYCLES cycles. Loss of any
// supply after qualification forces everything back into reset and raises a
// sticky fault flag.
//
// Ports:
//   clk_ref_24m  reference clock (only clock)
//   rst_n        asynchronous active-low reset
//   bus          serdesphy_reset_sequencer_if.slave (controls in, resets and
//                status out)
//
// Every output is registered and is computed from the next state, so it
// changes on the same edge as the state transition it belongs to.
// ---------------------------------------------------------------------------
module serdesphy_reset_sequencer #(
    parameter int NUM_SUPPLY    = 2,
    parameter int NUM_DOMAINS   = 3,
    parameter int CNT_W         = 8,
    parameter int STABLE_CYCLES = 16,
    parameter int STEP_CYCLES   = 8
) (
    input  logic                       clk_ref_24m,
    input  logic                       rst_n,
    serdesphy_reset_sequencer_if.slave bus
);
    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(STEP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_DOMAINS - 1);

    if (NUM_SUPPLY < 1 || NUM_DOMAINS < 1 || CNT_W < 1 || CNT_W > 30 ||
        STABLE_CYCLES < 1 || STABLE_CYCLES > (1 << CNT_W) ||
        STEP_CYCLES < 1 || STEP_CYCLES > (1 << CNT_W)) begin : g_paramCheck
        $error("serdesphy_reset_sequencer: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_OFF         = 3'd0,
        S_SUPPLY_WAIT = 3'd1,
        S_ISO_RELEASE = 3'd2,
        S_ANA_RESET   = 3'd3,
        S_DOM_RELEASE = 3'd4,
        S_RUN         = 3'd5,
        S_FAULT       = 3'd6
    } state_t;

    state_t                 r_state, w_nextState;
    logic [CNT_W-1:0]       r_timer, w_nextTimer, w_timerInc;
    logic [IDX_W-1:0]       r_domIdx, w_nextDomIdx;
    logic                   r_fault, w_nextFault;
    logic                   w_allOk;
    logic [NUM_DOMAINS-1:0] r_softActive, w_nextSoftActive;
    logic [CNT_W-1:0]       r_softTimer [NUM_DOMAINS];
    logic [CNT_W-1:0]       w_nextSoftTimer [NUM_DOMAINS];
    logic [NUM_DOMAINS-1:0] w_domMask;

    logic                   r_analogIsoN, w_analogIsoN;
    logic                   r_analogResetN, w_analogResetN;
    logic                   r_digitalResetN, w_digitalResetN;
    logic [NUM_DOMAINS-1:0] r_domainRstN, w_domainRstN;
    logic                   r_powerGood, w_powerGood;
    logic                   r_porActive, w_porActive;
    logic                   r_porComplete, w_porComplete;

    assign w_allOk    = &bus.supply_ok;
    // Saturating increment: the shared step timer never wraps.
    assign w_timerInc = (r_timer == CNT_MAX) ? r_timer : r_timer + CNT_ONE;

    // Next-state logic. Supply loss outranks disable, which outranks the
    // timed progression. Supply loss during SUPPLY_WAIT only restarts
    // qualification.
    always_comb begin
        w_nextState  = r_state;
        w_nextTimer  = r_timer;
        w_nextDomIdx = r_domIdx;
        w_nextFault  = r_fault;
        case (r_state)
            S_OFF: begin
                if (bus.phy_en) begin
                    w_nextState = S_SUPPLY_WAIT;
                    w_nextTimer = '0;
                    w_nextFault = 1'b0;
                end
            end
            S_SUPPLY_WAIT: begin
                if (!bus.phy_en) begin
                    w_nextState = S_OFF;
                end else if (!w_allOk) begin
                    w_nextTimer = '0;
                end else if (r_timer == STABLE_LAST) begin
                    w_nextState = S_ISO_RELEASE;
                    w_nextTimer = '0;
                end else begin
                    w_nextTimer = w_timerInc;
                end
            end
            S_ISO_RELEASE, S_ANA_RESET, S_DOM_RELEASE, S_RUN: begin
                if (!w_allOk) begin
                    w_nextState = S_FAULT;
                    w_nextFault = 1'b1;
                end else if (!bus.phy_en) begin
                    w_nextState = S_OFF;
                end else if (r_state != S_RUN) begin
                    if (r_timer == STEP_LAST) begin
                        w_nextTimer = '0;
                        if (r_state == S_ISO_RELEASE) begin
                            w_nextState = S_ANA_RESET;
                        end else if (r_state == S_ANA_RESET) begin
                            w_nextState  = S_DOM_RELEASE;
                            w_nextDomIdx = '0;
                        end else if (r_domIdx == IDX_LAST) begin
                            w_nextState = S_RUN;
                        end else begin
                            w_nextDomIdx = r_domIdx + IDX_ONE;
                        end
                    end else begin
                        w_nextTimer = w_timerInc;
                    end
                end
            end
            S_FAULT: begin
                if (!bus.phy_en) begin
                    w_nextState = S_OFF;
                end
            end
            default: w_nextState = S_OFF;
        endcase
    end

    // Per-domain soft-reset pulses. Only requests sampled while already in
    // RUN and staying in RUN count; a new request restarts that domain's
    // pulse. Leaving RUN drops all pulse state.
    always_comb begin
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            w_nextSoftActive[i] = 1'b0;
            w_nextSoftTimer[i]  = '0;
            if (r_state == S_RUN && w_nextState == S_RUN) begin
                if (bus.domain_rst_req[i]) begin
                    w_nextSoftActive[i] = 1'b1;
                end else if (r_softActive[i] && r_softTimer[i] != STEP_LAST) begin
                    w_nextSoftActive[i] = 1'b1;
                    w_nextSoftTimer[i]  = r_softTimer[i] + CNT_ONE;
                end
            end
        end
    end

    // Domains 0..index are released while stepping through DOM_RELEASE.
    always_comb begin
        w_domMask = '0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            w_domMask[i] = (IDX_W'(i) <= w_nextDomIdx);
        end
    end

    // Output decode from the next state so registered outputs line up with
    // the state register.
    always_comb begin
        w_analogIsoN    = 1'b0;
        w_analogResetN  = 1'b0;
        w_digitalResetN = 1'b0;
        w_domainRstN    = '0;
        w_powerGood     = 1'b0;
        w_porActive     = 1'b0;
        w_porComplete   = 1'b0;
        case (w_nextState)
            S_SUPPLY_WAIT: w_porActive = 1'b1;
            S_ISO_RELEASE: begin
                w_analogIsoN = ~bus.iso_en;
                w_powerGood  = 1'b1;
                w_porActive  = 1'b1;
            end
            S_ANA_RESET: begin
                w_analogIsoN   = ~bus.iso_en;
                w_analogResetN = 1'b1;
                w_powerGood    = 1'b1;
                w_porActive    = 1'b1;
            end
            S_DOM_RELEASE: begin
                w_analogIsoN    = ~bus.iso_en;
                w_analogResetN  = 1'b1;
                w_digitalResetN = 1'b1;
                w_domainRstN    = w_domMask;
                w_powerGood     = 1'b1;
                w_porActive     = 1'b1;
            end
            S_RUN: begin
                w_analogIsoN    = ~bus.iso_en;
                w_analogResetN  = 1'b1;
                w_digitalResetN = 1'b1;
                w_domainRstN    = ~w_nextSoftActive;
                w_powerGood     = 1'b1;
                w_porComplete   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_ref_24m or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_OFF;
            r_timer         <= '0;
            r_domIdx        <= '0;
            r_fault         <= 1'b0;
            r_softActive    <= '0;
            for (int i = 0; i < NUM_DOMAINS; i++) begin
                r_softTimer[i] <= '0;
            end
            r_analogIsoN    <= 1'b0;
            r_analogResetN  <= 1'b0;
            r_digitalResetN <= 1'b0;
            r_domainRstN    <= '0;
            r_powerGood     <= 1'b0;
            r_porActive     <= 1'b0;
            r_porComplete   <= 1'b0;
        end else begin
            r_state         <= w_nextState;
            r_timer         <= w_nextTimer;
            r_domIdx        <= w_nextDomIdx;
            r_fault         <= w_nextFault;
            r_softActive    <= w_nextSoftActive;
            for (int i = 0; i < NUM_DOMAINS; i++) begin
                r_softTimer[i] <= w_nextSoftTimer[i];
            end
            r_analogIsoN    <= w_analogIsoN;
            r_analogResetN  <= w_analogResetN;
            r_digitalResetN <= w_digitalResetN;
            r_domainRstN    <= w_domainRstN;
            r_powerGood     <= w_powerGood;
            r_porActive     <= w_porActive;
            r_porComplete   <= w_porComplete;
        end
    end

    assign bus.state           = r_state;
    assign bus.analog_iso_n    = r_analogIsoN;
    assign bus.analog_reset_n  = r_analogResetN;
    assign bus.digital_reset_n = r_digitalResetN;
    assign bus.domain_rst_n    = r_domainRstN;
    assign bus.power_good      = r_powerGood;
    assign bus.por_active      = r_porActive;
    assign bus.por_complete    = r_porComplete;
    assign bus.fault           = r_fault;
endmodule
